// File: rtl/figo_rover_nav.sv
// figo_rover_nav: ring-position navigation FSM for the FIGO land rover.
// Accepts one command at a time (HOLD / FWD / BACK / HOME) over a valid/ready
// handshake. Each step dwells STEP_CYCLES cycles; an obstacle seen at a
// step-commit edge parks the rover in BLOCKED until the path clears.
// Optional feature macro: FIGO_NAV_ODOMETER_EN (saturating move_count odometer;
// when undefined move_count is tied to zero).
module figo_rover_nav #(
    parameter int NUM_LOC     = 8,
    parameter int LOC_W       = 3,
    parameter int HOME_LOC    = 0,
    parameter int STEP_CYCLES = 1,
    parameter int MCNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    input  logic              obstacle,
    output logic [LOC_W-1:0]  current_location,
    output logic              busy,
    output logic              blocked,
    output logic              done,
    output logic [MCNT_W-1:0] move_count
);

    // Dwell counter only has to hold STEP_CYCLES-1; keep it at least one bit wide.
    localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DW-1:0]    DWELL_LOAD = DW'(STEP_CYCLES - 1);
    localparam logic [LOC_W-1:0] HOME_L     = LOC_W'(HOME_LOC);
    localparam logic [LOC_W-1:0] LAST_L     = LOC_W'(NUM_LOC - 1);
    // One extra bit so the modular distance can be formed without overflow.
    localparam logic [LOC_W:0]   RING       = (LOC_W + 1)'(NUM_LOC);
    localparam logic [LOC_W:0]   HALF_RING  = (LOC_W + 1)'(NUM_LOC / 2);

    // Command codes double as the resume-mode encoding.
    localparam logic [1:0] C_HOLD = 2'b00;
    localparam logic [1:0] C_FWD  = 2'b01;
    localparam logic [1:0] C_BACK = 2'b10;
    localparam logic [1:0] C_HOME = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_HOMING  = 2'd2,
        S_BLOCKED = 2'd3
    } state_t;

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic [DW-1:0]    dwell_reg;
    logic [LOC_W-1:0] loc_reg;
    logic             done_reg;

    logic [LOC_W-1:0] loc_inc;
    logic [LOC_W-1:0] loc_dec;
    logic [LOC_W-1:0] loc_step;
    logic [LOC_W:0]   home_dist;
    logic             home_fwd;
    logic             step_fwd;
    logic             moving;
    logic             commit_edge;
    logic             commit;

    // Neighbour locations on the ring, with wrap-around at both ends.
    always_comb begin
        loc_inc = (loc_reg == LAST_L) ? '0 : loc_reg + 1'b1;
        loc_dec = (loc_reg == '0) ? LAST_L : loc_reg - 1'b1;
    end

    // Forward distance to home, (HOME_LOC - loc) mod NUM_LOC; ties go forward.
    always_comb begin
        if (HOME_L >= loc_reg) begin
            home_dist = {1'b0, HOME_L} - {1'b0, loc_reg};
        end else begin
            home_dist = {1'b0, HOME_L} + RING - {1'b0, loc_reg};
        end
        home_fwd = (home_dist <= HALF_RING);
    end

    // Direction and destination of the step that would commit this cycle.
    always_comb begin
        step_fwd    = (state_reg == S_HOMING) ? home_fwd : (mode_reg == C_FWD);
        loc_step    = step_fwd ? loc_inc : loc_dec;
        moving      = (state_reg == S_STEP) || (state_reg == S_HOMING);
        commit_edge = moving && (dwell_reg == '0);
        commit      = commit_edge && !obstacle;
    end

    // Main navigation FSM with its registered location and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            mode_reg  <= C_FWD;
            dwell_reg <= '0;
            loc_reg   <= HOME_L;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            C_HOLD: begin
                                done_reg <= 1'b1;
                            end
                            C_FWD, C_BACK: begin
                                mode_reg  <= cmd;
                                dwell_reg <= DWELL_LOAD;
                                state_reg <= S_STEP;
                            end
                            default: begin
                                // HOME when already home completes without moving.
                                if (loc_reg == HOME_L) begin
                                    done_reg <= 1'b1;
                                end else begin
                                    mode_reg  <= C_HOME;
                                    dwell_reg <= DWELL_LOAD;
                                    state_reg <= S_HOMING;
                                end
                            end
                        endcase
                    end
                end
                S_STEP, S_HOMING: begin
                    if (commit) begin
                        loc_reg <= loc_step;
                        if ((state_reg == S_STEP) || (loc_step == HOME_L)) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            dwell_reg <= DWELL_LOAD;
                        end
                    end else if (commit_edge) begin
                        // Obstacle at the commit edge: no move, park until clear.
                        state_reg <= S_BLOCKED;
                    end else begin
                        dwell_reg <= dwell_reg - 1'b1;
                    end
                end
                S_BLOCKED: begin
                    if (!obstacle) begin
                        dwell_reg <= DWELL_LOAD;
                        state_reg <= (mode_reg == C_HOME) ? S_HOMING : S_STEP;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIGO_NAV_ODOMETER_EN
    logic [MCNT_W-1:0] mcnt_reg;

    // Saturating count of committed steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt_reg <= '0;
        end else if (commit && (mcnt_reg != '1)) begin
            mcnt_reg <= mcnt_reg + 1'b1;
        end
    end

    assign move_count = mcnt_reg;
`else
    assign move_count = '0;
`endif

    // Status decodes straight from the state register.
    assign cmd_ready        = (state_reg == S_IDLE);
    assign busy             = (state_reg != S_IDLE);
    assign blocked          = (state_reg == S_BLOCKED);
    assign current_location = loc_reg;
    assign done             = done_reg;

endmodule

// File: tb/tb_figo_rover_nav.sv
// Scoreboard testbench for figo_rover_nav (NUM_LOC=8, HOME_LOC=0,
// STEP_CYCLES=3, MCNT_W=4). The driver issues commands and pushes the
// expected completion and the expected location trail; an independent
// monitor checks every location change and every done pulse.
module tb_figo_rover_nav;

    localparam int N    = 8;
    localparam int LW   = 3;
    localparam int HOME = 0;
    localparam int S    = 3;
    localparam int MW   = 4;
    localparam int MAXC = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic          obstacle = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] current_location;
    logic          busy;
    logic          blocked;
    logic          done;
    logic [MW-1:0] move_count;

    figo_rover_nav #(
        .NUM_LOC(N), .LOC_W(LW), .HOME_LOC(HOME), .STEP_CYCLES(S), .MCNT_W(MW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .cmd_ready(cmd_ready),
        .obstacle(obstacle),
        .current_location(current_location),
        .busy(busy),
        .blocked(blocked),
        .done(done),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int loc;
        int cnt;
        int lat;
        bit chk_lat;
        int acc;
        int op;
    } exp_t;

    exp_t sb[$];
    int   path_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   m_loc = HOME;
    int   m_cnt = 0;
    bit   obs_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: final position, trail of visited locations, step count.
    task automatic model_cmd(input int c, input bit chk, output exp_t e);
        int steps;
        int d;
        steps = 0;
        if (c == 1) begin
            m_loc = (m_loc + 1) % N;
            path_q.push_back(m_loc);
            steps = 1;
        end else if (c == 2) begin
            m_loc = (m_loc + N - 1) % N;
            path_q.push_back(m_loc);
            steps = 1;
        end else if (c == 3) begin
            while (m_loc != HOME) begin
                d = (HOME - m_loc + N) % N;
                m_loc = (d <= N / 2) ? (m_loc + 1) % N : (m_loc + N - 1) % N;
                path_q.push_back(m_loc);
                steps++;
            end
        end
`ifdef FIGO_NAV_ODOMETER_EN
        m_cnt = (m_cnt + steps > MAXC) ? MAXC : m_cnt + steps;
`else
        m_cnt = 0;
`endif
        e.loc     = m_loc;
        e.cnt     = m_cnt;
        e.lat     = steps * S;
        e.chk_lat = chk;
        e.acc     = cyc + 1;
        e.op      = c;
    endtask

    // Called at a falling edge; holds cmd_valid (with junk cmd) until ready.
    task automatic issue(input int c, input bit chk);
        exp_t e;
        int t;
        cmd_valid = 1'b1;
        cmd = 2'($urandom);
        t = 0;
        while (!cmd_ready && t < 300) begin
            @(negedge clk);
            cmd = 2'($urandom);
            t++;
        end
        if (!cmd_ready) begin
            fail_now("ready_timeout");
            cmd_valid = 1'b0;
            return;
        end
        cmd = 2'(c);
        model_cmd(c, chk, e);
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || busy) fail_now("idle_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_loc"}, current_location, HOME);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_blocked"}, blocked, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_mcnt"}, move_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        cmd_valid = 1'b0;
        obstacle = 1'b0;
        sb.delete();
        path_q.delete();
        m_loc = HOME;
        m_cnt = 0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (obs_en) obstacle = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: trail of locations, done-time scoreboard compare, status relations.
    initial begin
        int   prev_loc;
        int   busy_cnt;
        exp_t e;
        prev_loc = HOME;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_loc = HOME;
                busy_cnt = 0;
                check("done_in_reset", done, 0);
            end else begin
                check("busy_vs_ready", busy, !cmd_ready);
                check("blocked_without_busy", blocked && !busy, 0);
                if (busy) busy_cnt++;
                if (int'(current_location) != prev_loc) begin
                    if (path_q.size() == 0) fail_now("path_unexpected_move");
                    else check("path_loc", current_location, path_q.pop_front());
                    prev_loc = current_location;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        fail_now("done_unexpected");
                    end else begin
                        e = sb.pop_front();
                        check("done_loc", current_location, e.loc);
                        check("done_mcnt", move_count, e.cnt);
                        if (e.chk_lat) begin
                            check("latency", cyc - e.acc, e.lat);
                            check("busy_cycles", busy_cnt, e.lat);
                        end
                        $display("txn op=%0d loc=%0d mcnt=%0d cyc=%0d", e.op,
                                 current_location, move_count, cyc);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);

        // FWD x3 from home.
        for (int i = 0; i < 3; i++) issue(1, 1'b1);
        wait_idle();
        check("fwd3_loc", current_location, 3);

        // Return home, then BACK wraps to 7 and FWD wraps back to 0.
        issue(3, 1'b1);
        issue(2, 1'b1);
        issue(1, 1'b1);
        wait_idle();
        check("wrap_loc", current_location, 0);

        // HOME from 0 (no move), 6, 3 and 4 (tie goes forward); HOLD in between.
        issue(3, 1'b1);
        issue(0, 1'b1);
        issue(2, 1'b1);
        issue(2, 1'b1);
        issue(3, 1'b1);
        for (int i = 0; i < 3; i++) issue(1, 1'b1);
        issue(3, 1'b1);
        for (int i = 0; i < 4; i++) issue(1, 1'b1);
        issue(3, 1'b1);
        wait_idle();
        check("home_loc", current_location, HOME);

        // Obstacle at the commit edge of FWD from 2.
        issue(1, 1'b1);
        issue(1, 1'b1);
        wait_idle();
        obstacle = 1'b1;
        issue(1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("obs_pre_blocked", blocked, 0);
        end
        @(negedge clk);
        check("obs_blocked", blocked, 1);
        check("obs_loc_held", current_location, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("obs_hold_blocked", blocked, 1);
            check("obs_hold_loc", current_location, 2);
        end
        obstacle = 1'b0;
        @(negedge clk);
        check("obs_release_blocked", blocked, 0);
        check("obs_release_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("obs_dwell_loc", current_location, 2);
        end
        @(negedge clk);
        check("obs_commit_loc", current_location, 3);
        wait_idle();

        // Reset in the middle of HOMING from 5.
        issue(1, 1'b1);
        issue(1, 1'b1);
        wait_idle();
        check("pre_home_loc", current_location, 5);
        issue(3, 1'b1);
        repeat (3) @(negedge clk);
        check("mid_home_busy", busy, 1);
        do_reset();
        check("post_reset_loc", current_location, HOME);

        // Random commands, no obstacle: full latency checking.
        for (int i = 0; i < 60; i++) begin
            issue($urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Random commands with random obstacles: position and count only.
        obs_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        obs_en = 1'b0;
        #1;
        obstacle = 1'b0;
        wait_idle();
        check("final_path_empty", path_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
